// File: rtl/div_bcd_fmt.sv
// div_bcd_fmt: captures the signed divider's quotient and remainder on Div_Done
// and converts both to packed BCD by sequential shift-add-3 (double dabble).
// Quotient is converted as a magnitude, with the sign reported on Q_Neg.
module div_bcd_fmt #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Div_Done,
  input  logic [W-1:0]          Quotient,
  input  logic [W-1:0]          Reminder,
  output logic                  Busy,
  output logic                  Fmt_Done,
  output logic                  Q_Neg,
  output logic [4*DIGITS-1:0]   Q_BCD,
  output logic [4*DIGITS-1:0]   R_BCD
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   q_mag, r_mag;
  logic [BW-1:0]  q_bcd, r_bcd;
  logic           neg_l;
  logic [W-1:0]   q_mag_nx, r_mag_nx;
  logic [BW-1:0]  q_bcd_nx, r_bcd_nx;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One double-dabble step for both operands: adjust, then shift {bcd,mag} left.
  // The BCD MSB shifted out is always zero for in-range operands, so it is dropped.
  always_comb begin
    q_bcd_nx = BW'({add3(q_bcd), q_mag[W-1]});
    r_bcd_nx = BW'({add3(r_bcd), r_mag[W-1]});
    q_mag_nx = {q_mag[W-2:0], 1'b0};
    r_mag_nx = {r_mag[W-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: start on Div_Done, return to IDLE after W shift steps.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Div_Done) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Busy = (state == SHIFT);

  // Capture, shift datapath and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt      <= '0;
      q_mag    <= '0;
      r_mag    <= '0;
      q_bcd    <= '0;
      r_bcd    <= '0;
      neg_l    <= 1'b0;
      Fmt_Done <= 1'b0;
      Q_Neg    <= 1'b0;
      Q_BCD    <= '0;
      R_BCD    <= '0;
    end else begin
      Fmt_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Div_Done) begin
            q_mag <= Quotient[W-1] ? (~Quotient + 1'b1) : Quotient;
            r_mag <= Reminder;
            neg_l <= Quotient[W-1];
            q_bcd <= '0;
            r_bcd <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          q_bcd <= q_bcd_nx;
          r_bcd <= r_bcd_nx;
          q_mag <= q_mag_nx;
          r_mag <= r_mag_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            Q_BCD    <= q_bcd_nx;
            R_BCD    <= r_bcd_nx;
            Q_Neg    <= neg_l;
            Fmt_Done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_fmt.sv
// Bench for div_bcd_fmt: a latency/decimal-arithmetic model checked every cycle,
// plus directed cases with literal expected values.
module tb_div_bcd_fmt;

  logic        CLK;
  logic        RSTn;
  logic        Div_Done;
  logic [7:0]  Quotient;
  logic [7:0]  Reminder;
  logic        Busy;
  logic        Fmt_Done;
  logic        Q_Neg;
  logic [11:0] Q_BCD;
  logic [11:0] R_BCD;

  int checks   = 0;
  int failures = 0;
  int fmt_seen = 0;
  bit chk_en   = 0;

  div_bcd_fmt #(.W(8), .DIGITS(3)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Div_Done (Div_Done),
    .Quotient (Quotient),
    .Reminder (Reminder),
    .Busy     (Busy),
    .Fmt_Done (Fmt_Done),
    .Q_Neg    (Q_Neg),
    .Q_BCD    (Q_BCD),
    .R_BCD    (R_BCD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of an integer 0..999 as packed BCD.
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: a conversion takes 8 edges after the capture edge; a new
  // request is only accepted when no conversion is outstanding.
  int          m_rem;
  logic [11:0] m_q, m_r, p_q, p_r;
  logic        m_neg, p_neg, m_fmt;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_rem <= 0; m_fmt <= 1'b0; m_neg <= 1'b0; m_q <= '0; m_r <= '0;
      p_q <= '0; p_r <= '0; p_neg <= 1'b0;
    end else begin
      m_fmt <= 1'b0;
      if (m_rem == 0) begin
        if (Div_Done) begin
          m_rem <= 8;
          p_neg <= Quotient[7];
          p_q   <= to_bcd(Quotient[7] ? 256 - int'(Quotient) : int'(Quotient));
          p_r   <= to_bcd(int'(Reminder));
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_q <= p_q; m_r <= p_r; m_neg <= p_neg; m_fmt <= 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy",     {31'd0, Busy},     {31'd0, m_rem != 0});
      check("fmt_done", {31'd0, Fmt_Done}, {31'd0, m_fmt});
      check("q_neg",    {31'd0, Q_Neg},    {31'd0, m_neg});
      check("q_bcd",    {20'd0, Q_BCD},    {20'd0, m_q});
      check("r_bcd",    {20'd0, R_BCD},    {20'd0, m_r});
      if (Fmt_Done) fmt_seen++;
    end
  end

  // Called at a falling edge: present a one-cycle Div_Done pulse.
  task automatic pulse(input logic [7:0] q, input logic [7:0] r);
    Div_Done = 1'b1; Quotient = q; Reminder = r;
    @(negedge CLK);
    Div_Done = 1'b0;
  endtask

  // Count falling edges until Fmt_Done, bounded; compare against expected latency.
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!Fmt_Done && n < 20);
    check(name, n, exp_n);
  endtask

  task automatic expect_out(input string name, input logic neg, input logic [11:0] q, input logic [11:0] r);
    check({name, "_neg"}, {31'd0, Q_Neg}, {31'd0, neg});
    check({name, "_q"},   {20'd0, Q_BCD}, {20'd0, q});
    check({name, "_r"},   {20'd0, R_BCD}, {20'd0, r});
  endtask

  initial begin
    int f0;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int f0;
    RSTn = 1'b1; Div_Done = 1'b0; Quotient = '0; Reminder = '0;
    #1 RSTn = 1'b0;
    #2 chk_en = 1'b1;
    @(negedge CLK);
    expect_out("reset", 1'b0, 12'h000, 12'h000);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    #2 RSTn = 1'b1;
    @(negedge CLK);

    // 1: positive quotient
    pulse(8'h0E, 8'h02);
    wait_done("t1_latency", 8);
    expect_out("t1", 1'b0, 12'h014, 12'h002);

    // 2: negative quotient
    @(negedge CLK);
    pulse(8'hF2, 8'h02);
    wait_done("t2_latency", 8);
    expect_out("t2", 1'b1, 12'h014, 12'h002);

    // 3: extremes, then zero
    @(negedge CLK);
    pulse(8'h80, 8'hFF);
    wait_done("t3a_latency", 8);
    expect_out("t3a", 1'b1, 12'h128, 12'h255);
    @(negedge CLK);
    pulse(8'h00, 8'h00);
    wait_done("t3b_latency", 8);
    expect_out("t3b", 1'b0, 12'h000, 12'h000);

    // divide-by-zero pattern formatted as-is
    @(negedge CLK);
    pulse(8'hFF, 8'h0C);
    wait_done("dbz_latency", 8);
    expect_out("dbz", 1'b1, 12'h001, 12'h012);

    // 4: Div_Done during SHIFT is ignored
    @(negedge CLK);
    f0 = fmt_seen;
    pulse(8'h0E, 8'h02);
    repeat (2) @(negedge CLK);
    pulse(8'h63, 8'h07);
    wait_done("t4_latency", 5);
    expect_out("t4", 1'b0, 12'h014, 12'h002);
    repeat (12) @(negedge CLK);
    check("t4_fmt_count", fmt_seen - f0, 1);

    // 5: reset mid-conversion aborts it
    pulse(8'h2A, 8'h05);
    repeat (3) @(negedge CLK);
    f0 = fmt_seen;
    #2 RSTn = 1'b0;
    #1;
    check("t5_busy", {31'd0, Busy}, 32'd0);
    check("t5_fmt", {31'd0, Fmt_Done}, 32'd0);
    expect_out("t5", 1'b0, 12'h000, 12'h000);
    @(negedge CLK);
    #2 RSTn = 1'b1;
    repeat (12) @(negedge CLK);
    check("t5_fmt_count", fmt_seen - f0, 0);
    pulse(8'h05, 8'h03);
    wait_done("t5b_latency", 8);
    expect_out("t5b", 1'b0, 12'h005, 12'h003);

    // 6: back-to-back, accepted in the Fmt_Done cycle
    pulse(8'h7F, 8'h09);
    wait_done("t6_latency", 8);
    expect_out("t6", 1'b0, 12'h127, 12'h009);

    // Operand sweeps, back-to-back, checked by the per-cycle model
    for (int i = 0; i < 256; i++) begin
      pulse(8'(i), 8'(i) ^ 8'hA5);
      wait_done("sweep_q_latency", 8);
    end
    for (int i = 0; i < 256; i++) begin
      pulse(8'(255 - i), 8'(i));
      wait_done("sweep_r_latency", 8);
    end

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
